// File: rtl/chg_capture_pkg.sv
// Shared types and defaults for the change-capture block.
package chg_capture_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int TSW_DEF   = 8;
  localparam int DATA_W    = 8;

  // Entry layout at default timestamp width: data in the upper bits, stamp below.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [TSW_DEF-1:0] ts;
  } chg_entry_t;

endpackage

// File: rtl/chg_fifo.sv
// Show-ahead FIFO holding captured entries; push is accepted when full only
// if a pop happens on the same edge.
module chg_fifo
  import chg_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = DATA_W + TSW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          do_pop_s;
  logic          do_push_s;

  assign full     = (count_r == CNT_MAX);
  assign empty    = (count_r == '0);
  assign count    = count_r;
  assign head     = mem[rd_ptr_r];
  assign do_pop_s = pop && !empty;

  // A full FIFO only takes a push when the head leaves on the same edge.
  always_comb begin
    if (full) begin
      do_push_s = push && do_pop_s;
    end else begin
      do_push_s = push;
    end
  end

  // Occupancy update for push/pop combinations.
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy state; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
    end
  end

  // Storage write; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/chg_capture.sv
// Captures changes of the input byte with a free-running cycle stamp into a
// small FIFO; drops on a full FIFO raise a sticky overflow flag.
module chg_capture
  import chg_capture_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int TSW   = TSW_DEF
) (
  input  logic                     cclk,
  input  logic                     rst_n,
  input  logic [7:0]               cin,
  input  logic                     en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [TSW-1:0]           out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int W = DATA_W + TSW;

  logic [TSW-1:0]    ts_r;
  logic [7:0]        prev_r;
  logic              ovf_r;
  logic              ovf_next_s;
  logic              change_s;
  logic              pop_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic [W-1:0]      head_s;

  assign change_s  = en && (cin != prev_r);
  assign pop_s     = !empty_s && out_ready;
  assign drop_s    = change_s && full_s && !pop_s;
  assign out_valid = !empty_s;
  assign out_data  = head_s[W-1:TSW];
  assign out_ts    = head_s[TSW-1:0];
  assign overflow  = ovf_r;

  // Overflow: a drop on the same edge as a clear keeps the flag set.
  always_comb begin
    if (drop_s) begin
      ovf_next_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Timestamp, previous-sample and overflow registers.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r   <= '0;
      prev_r <= 8'h00;
      ovf_r  <= 1'b0;
    end else begin
      ts_r   <= ts_r + TSW'(1);
      prev_r <= cin;
      ovf_r  <= ovf_next_s;
    end
  end

  chg_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (cclk),
    .rst_n (rst_n),
    .push  (change_s),
    .pop   (pop_s),
    .din   ({cin, ts_r}),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count)
  );

endmodule

// File: tb/tb_chg_capture.sv
// Directed and random checks of chg_capture against a queue-based reference.
module tb_chg_capture;
  import chg_capture_pkg::*;

  localparam int DEPTH = 4;
  localparam int TSW   = 8;

  logic       cclk;
  logic       rst_n;
  logic [7:0] cin;
  logic       en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_ts;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int total;
  int bad;

  chg_entry_t mq[$];
  logic [7:0] m_ts;
  logic [7:0] m_prev;
  logic       m_ovf;

  chg_capture #(.DEPTH(DEPTH), .TSW(TSW)) dut (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .cin       (cin),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid", 32'(out_valid), 32'(mq.size() != 0));
    check("count", 32'(count), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) begin
      check("head_data", 32'(out_data), 32'(mq[0].data));
      check("head_ts", 32'(out_ts), 32'(mq[0].ts));
    end
  endtask

  // One clock: update the reference from the inputs seen at the edge, check at negedge.
  task automatic step();
    bit pop;
    bit chg;
    bit drop;
    chg_entry_t e;
    @(posedge cclk);
    pop  = (mq.size() > 0) && out_ready;
    chg  = en && (cin != m_prev);
    drop = chg && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (chg && !drop) begin
      e.data = cin;
      e.ts   = m_ts;
      mq.push_back(e);
    end
    if (drop) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_prev = cin;
    m_ts   = m_ts + 8'd1;
    @(negedge cclk);
    check_all();
  endtask

  // Called at a negedge: asserts reset between edges, checks it took hold at once.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_ts   = 8'd0;
    m_prev = 8'd0;
    m_ovf  = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge cclk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cin = 8'd0; en = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    mq.delete(); m_ts = 8'd0; m_prev = 8'd0; m_ovf = 1'b0;
    #2;
    check("init_valid", 32'(out_valid), 32'd0);
    check("init_count", 32'(count), 32'd0);
    check("init_ovf", 32'(overflow), 32'd0);
    @(negedge cclk);
    rst_n = 1'b1;

    // Constant input produces nothing.
    en = 1'b1; out_ready = 1'b1; cin = 8'd0;
    for (int i = 0; i < 5; i++) step();
    check("quiet_count", 32'(count), 32'd0);

    // Four changes from ts=3, then drain in order.
    pulse_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 1; i <= 4; i++) begin
      cin = 8'(i);
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    en = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("seq_data", 32'(out_data), 32'(i));
      check("seq_ts", 32'(out_ts), 32'(i + 2));
      step();
    end
    check("drained", 32'(out_valid), 32'd0);

    // Overflow on a full FIFO, then clear.
    en = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cin = 8'(i);
      step();
    end
    cin = 8'd5;
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    clr_ovf = 1'b1;
    step();
    check("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b0;

    // Full with simultaneous pop and push.
    out_ready = 1'b1; cin = 8'd9;
    step();
    check("fullpp_count", 32'(count), 32'd4);
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_head", 32'(out_data), 32'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) check("never5", 32'(out_data == 8'd5), 32'd0);
      step();
    end

    // Timestamp wrap: changes at ts=255 and the following edge.
    for (int i = 0; i < 300 && m_ts != 8'd255; i++) step();
    out_ready = 1'b0; en = 1'b1;
    cin = 8'h11; step();
    cin = 8'h22; step();
    check("wrap_count", 32'(count), 32'd2);
    check("wrap_ts0", 32'(out_ts), 32'd255);
    en = 1'b0; out_ready = 1'b1;
    step();
    check("wrap_ts1", 32'(out_ts), 32'd0);
    out_ready = 1'b0; en = 1'b1;
    cin = 8'h33; step();
    cin = 8'h44; step();
    check("pre_rst_count", 32'(count), 32'd3);

    // Mid-operation reset discards contents; cin=0 afterwards is no change.
    cin = 8'd0;
    pulse_reset();
    step();
    check("post_rst_count", 32'(count), 32'd0);

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      cin       = 8'($urandom_range(0, 3));
      en        = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
